// File: rtl/buzzer_arbiter_if.sv
// Buzzer request/grant bundle between requesters and the arbiter.
// The arbiter side (slave) owns grant, busy and out.
interface buzzer_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic       busy;
  logic       out;

  modport master (
    output req,
    input  grant,
    input  busy,
    input  out
  );

  modport slave (
    input  req,
    output grant,
    output busy,
    output out
  );
endinterface

// File: rtl/buzzer_arbiter.sv
// Round-robin arbiter sharing one buzzer among four tone requesters.
// Each grant plays a square wave for up to SLOT cycles, then GAP silence.
module buzzer_arbiter #(
  parameter int HALF0 = 6000,
  parameter int HALF1 = 3000,
  parameter int HALF2 = 2000,
  parameter int HALF3 = 1500,
  parameter int SLOT  = 12_000_000,
  parameter int GAP   = 1_200_000
) (
  input logic clk,
  input logic rst,
  buzzer_arbiter_if.slave bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MXH = max2(max2(HALF0, HALF1), max2(HALF2, HALF3));
  localparam int MX  = max2(MXH, max2(SLOT, GAP));
  localparam int CW  = $clog2(MX + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    ptr;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hlim;
  logic [3:0]    grant_q;
  logic          busy_q;
  logic          out_q;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic          hit;
  logic          rel;

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.out   = out_q;

  // ptr holds the granted index while playing
  always_comb begin
    hlim = CW'(HALF0 - 1);
    unique case (1'b1)
      (ptr == 2'd0): hlim = CW'(HALF0 - 1);
      (ptr == 2'd1): hlim = CW'(HALF1 - 1);
      (ptr == 2'd2): hlim = CW'(HALF2 - 1);
      (ptr == 2'd3): hlim = CW'(HALF3 - 1);
      default:       hlim = CW'(HALF0 - 1);
    endcase
  end

  always_comb begin
    win = ptr;
    hit = 1'b0;
    idx = ptr;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!hit && bus.req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end

  assign rel = ~|(bus.req & grant_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= 2'd3;
      hcnt    <= '0;
      cnt     <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            state   <= ST_PLAY;
            ptr     <= win;
            grant_q <= 4'(1) << win;
            busy_q  <= 1'b1;
            hcnt    <= '0;
            cnt     <= '0;
            out_q   <= 1'b0;
          end
        end
        ST_PLAY: begin
          // expiry and release collapse into one exit
          if (cnt == CW'(SLOT - 1) || rel) begin
            state   <= ST_GAP;
            grant_q <= '0;
            out_q   <= 1'b0;
            hcnt    <= '0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (hcnt == hlim) begin
              hcnt  <= '0;
              out_q <= ~out_q;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (cnt == CW'(GAP - 1)) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          out_q   <= 1'b0;
          hcnt    <= '0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter with short tones, slot and gap.
// Expected grant/out/busy values are computed from the cycle index.
module tb_buzzer_arbiter;

  localparam int SLOT = 20;
  localparam int GAPC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  buzzer_arbiter_if bus ();

  buzzer_arbiter #(
    .HALF0(2),
    .HALF1(3),
    .HALF2(4),
    .HALF3(5),
    .SLOT (SLOT),
    .GAP  (GAPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic play_cycles(input logic [3:0] g, input int h,
                             input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      chk("play_grant", bus.grant, g);
      chk("play_busy", {3'b0, bus.busy}, 4'b0001);
      chk("play_out", {3'b0, bus.out}, 4'(((k / h) % 2)));
      tick();
    end
  endtask

  task automatic gap_cycles();
    for (int k = 0; k < GAPC; k++) begin
      chk("gap_grant", bus.grant, 4'b0000);
      chk("gap_busy", {3'b0, bus.busy}, 4'b0001);
      chk("gap_out", {3'b0, bus.out}, 4'b0000);
      tick();
    end
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_grant"}, bus.grant, 4'b0000);
    chk({tag, "_busy"}, {3'b0, bus.busy}, 4'b0000);
    chk({tag, "_out"}, {3'b0, bus.out}, 4'b0000);
  endtask

  logic [3:0] rr_exp [5];
  int         rr_half [5];

  initial begin
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_half = '{2, 3, 4, 5, 2};

    // reset wins over a pending request
    bus.req = 4'b1111;
    rst = 1'b1;
    tick();
    tick();
    idle_check("rst_hold");
    bus.req = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    idle_check("reset");

    // full round robin with all requests held
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      play_cycles(rr_exp[i], rr_half[i], 0, SLOT);
      gap_cycles();
      idle_check("rr_idle");
    end
    bus.req = 4'b0000;
    tick();
    idle_check("rr_quiet");

    // single requester, full slot of tone 1
    bus.req = 4'b0010;
    tick();
    play_cycles(4'b0010, 3, 0, SLOT);
    gap_cycles();
    idle_check("t1_idle");
    bus.req = 4'b0000;

    // tone 2 released at play cycle 7
    tick();
    bus.req = 4'b0100;
    tick();
    play_cycles(4'b0100, 4, 0, 7);
    bus.req = 4'b0000;
    play_cycles(4'b0100, 4, 7, 1);
    gap_cycles();
    idle_check("rel_idle");

    // late requester waits, no preemption
    bus.req = 4'b0001;
    tick();
    play_cycles(4'b0001, 2, 0, 5);
    bus.req = 4'b1001;
    play_cycles(4'b0001, 2, 5, SLOT - 5);
    gap_cycles();
    idle_check("pre_idle");
    tick();
    chk("no_preempt_next", bus.grant, 4'b1000);

    // reset mid-play while out is high
    play_cycles(4'b1000, 5, 0, 6);
    chk("rst_pre_out", {3'b0, bus.out}, 4'b0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_check("mid_rst");
    tick();
    chk("post_rst_win", bus.grant, 4'b0001);

    // finish that grant, then drop on the final slot cycle
    bus.req = 4'b0001;
    play_cycles(4'b0001, 2, 0, SLOT);
    gap_cycles();
    idle_check("pr_idle");
    bus.req = 4'b0010;
    tick();
    play_cycles(4'b0010, 3, 0, SLOT - 1);
    bus.req = 4'b0000;
    play_cycles(4'b0010, 3, SLOT - 1, 1);
    gap_cycles();
    idle_check("last_idle");
    tick();
    idle_check("last_quiet");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
